// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read / dual-write register file with token-gated commits
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding)
module regfile_mp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_RD         = 2,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic                     wa_token,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic                     wb_token,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wa_ack,
  output logic                     wb_ack
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic buf_a, buf_b;
  logic commit_a, commit_b;
  logic we_a, we_b;

  // A commit is only meaningful outside reset; a pending request during reset is dropped.
  assign commit_a = reset_n && wa_en && (wa_token != buf_a);
  assign commit_b = reset_n && wb_en && (wb_token != buf_b);
  assign we_a     = commit_a && !((ZERO_REG != 0) && (wa_addr == '0));
  assign we_b     = commit_b && !((ZERO_REG != 0) && (wb_addr == '0));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      buf_a  <= 1'b1;
      buf_b  <= 1'b1;
      wa_ack <= 1'b0;
      wb_ack <= 1'b0;
    end else begin
      wa_ack <= commit_a;
      wb_ack <= commit_b;
      if (commit_a) buf_a <= wa_token;
      if (commit_b) buf_b <= wb_token;
    end
  end

  // Port B is written first so port A wins a same-address collision.
  if (CLEAR_ON_RESET != 0) begin : g_clr
    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
        if (we_b) mem[wb_addr] <= wb_data;
        if (we_a) mem[wa_addr] <= wa_data;
      end
    end
  end else begin : g_keep
    always_ff @(posedge CLK) begin
      if (we_b) mem[wb_addr] <= wb_data;
      if (we_a) mem[wa_addr] <= wa_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] q;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      nxt = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (we_a && (wa_addr == ra))      nxt = wa_data;
      else if (we_b && (wb_addr == ra)) nxt = wb_data;
`endif
      if ((ZERO_REG != 0) && (ra == '0)) nxt = '0;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n)    q <= '0;
      else if (!stall) q <= nxt;
    end

    assign rd_data[i*DATA_W +: DATA_W] = q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard testbench for regfile_mp (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        reset_n, stall;
  logic [4:0]  ra0, ra1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data0;
  logic        wa_en, wa_token, wb_en, wb_token;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_ack, wb_ack, wa_ack0, wb_ack0;

  assign rd_addr = {ra1, ra0};

  always #5 CLK = ~CLK;

  regfile_mp dut (
    .CLK(CLK), .reset_n(reset_n), .stall(stall), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_en(wa_en), .wa_token(wa_token), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_token(wb_token), .wb_addr(wb_addr), .wb_data(wb_data),
    .wa_ack(wa_ack), .wb_ack(wb_ack)
  );

  regfile_mp #(.ZERO_REG(0)) dut0 (
    .CLK(CLK), .reset_n(reset_n), .stall(stall), .rd_addr(rd_addr), .rd_data(rd_data0),
    .wa_en(wa_en), .wa_token(wa_token), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_token(wb_token), .wb_addr(wb_addr), .wb_data(wb_data),
    .wa_ack(wa_ack0), .wb_ack(wb_ack0)
  );

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rz;
    logic        aa;
    logic        ab;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  logic        mbuf_a, mbuf_b;
  logic [31:0] hold0, hold1, holdz;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] rmodel(input bit z, input logic [4:0] a, input bit ca, input bit cb);
    logic [31:0] v;
    v = z ? m1[a] : m0[a];
`ifdef REGFILE_BYPASS_EN
    if (ca && wa_addr == a)      v = wa_data;
    else if (cb && wb_addr == a) v = wb_data;
`endif
    if (z && a == 5'd0) v = 32'h0;
    return v;
  endfunction

  task automatic tick();
    exp_t e;
    logic ca, cb;
    ca = wa_en && (wa_token != mbuf_a);
    cb = wb_en && (wb_token != mbuf_b);
    e.aa = ca;
    e.ab = cb;
    if (stall) begin
      e.rd0 = hold0; e.rd1 = hold1; e.rz = holdz;
    end else begin
      e.rd0 = rmodel(1, ra0, ca, cb);
      e.rd1 = rmodel(1, ra1, ca, cb);
      e.rz  = rmodel(0, ra0, ca, cb);
    end
    hold0 = e.rd0; hold1 = e.rd1; holdz = e.rz;
    sbq.push_back(e);
    @(posedge CLK); #1;
    if (cb) begin
      mbuf_b = wb_token;
      m0[wb_addr] = wb_data;
      if (wb_addr != 5'd0) m1[wb_addr] = wb_data;
    end
    if (ca) begin
      mbuf_a = wa_token;
      m0[wa_addr] = wa_data;
      if (wa_addr != 5'd0) m1[wa_addr] = wa_data;
    end
  endtask

  task automatic model_reset();
    mbuf_a = 1'b1; mbuf_b = 1'b1;
    hold0 = '0; hold1 = '0; holdz = '0;
    sbq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; ra0 = '0; ra1 = '0;
    wa_en = 1'b1; wa_token = 1'b0; wa_addr = 5'd2; wa_data = 32'hBAD0_0002;
    wb_en = 1'b0; wb_token = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_chk++; if ({wa_ack, wb_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got=%b exp=00", {wa_ack, wb_ack}); end
    wa_en = 1'b0;
    reset_n = 1'b1;
    ra1 = 5'd2;
    tick();
    begin
      exp_t e; e = sbq.pop_front();
      n_chk++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL reset_lost_commit got=%h exp=0", rd_data[63:32]); end
      n_chk++; if (rd_data[63:32] !== e.rd1) begin n_fail++; $display("FAIL reset_rd1_model got=%h exp=%h", rd_data[63:32], e.rd1); end
    end
  endtask

  task automatic test_basic_write();
    exp_t e;
    wa_en = 1'b1; wa_token = 1'b0; wa_addr = 5'd3; wa_data = 32'hDEAD_BEEF;
    tick(); e = sbq.pop_front();
    n_chk++; if (wa_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack got=%b exp=1", wa_ack); end
    n_chk++; if (wa_ack !== e.aa) begin n_fail++; $display("FAIL basic_ack_model got=%b exp=%b", wa_ack, e.aa); end
    wa_en = 1'b0; ra0 = 5'd3;
    tick(); e = sbq.pop_front();
    n_chk++; if (wa_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse got=%b exp=0", wa_ack); end
    n_chk++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_read got=%h exp=deadbeef", rd_data[31:0]); end
    n_chk++; if (rd_data[31:0] !== e.rd0) begin n_fail++; $display("FAIL basic_read_model got=%h exp=%h", rd_data[31:0], e.rd0); end
  endtask

  task automatic test_hold_token();
    exp_t e;
    int acks;
    logic tok;
    acks = 0;
    tok = ~mbuf_a;
    wa_en = 1'b1; wa_token = tok; wa_addr = 5'd5;
    for (int i = 0; i < 5; i++) begin
      wa_data = 32'h100 + i;
      tick(); e = sbq.pop_front();
      if (wa_ack === 1'b1) acks++;
      n_chk++; if (wa_ack !== e.aa) begin n_fail++; $display("FAIL hold_ack_%0d got=%b exp=%b", i, wa_ack, e.aa); end
    end
    n_chk++; if (acks !== 1) begin n_fail++; $display("FAIL hold_commit_count got=%0d exp=1", acks); end
    wa_token = ~tok; wa_data = 32'h5;
    tick(); e = sbq.pop_front();
    n_chk++; if (wa_ack !== 1'b1) begin n_fail++; $display("FAIL hold_toggle_ack got=%b exp=1", wa_ack); end
    wa_en = 1'b0; ra1 = 5'd5;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[63:32] !== 32'h5) begin n_fail++; $display("FAIL hold_toggle_data got=%h exp=5", rd_data[63:32]); end
  endtask

  task automatic test_dual();
    exp_t e;
    wa_en = 1'b1; wa_token = ~mbuf_a; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_token = ~mbuf_b; wb_addr = 5'd7; wb_data = 32'h22;
    tick(); e = sbq.pop_front();
    n_chk++; if ({wa_ack, wb_ack} !== 2'b11) begin n_fail++; $display("FAIL dual_acks got=%b exp=11", {wa_ack, wb_ack}); end
    wa_en = 1'b0; wb_en = 1'b0; ra0 = 5'd7;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[31:0] !== 32'h11) begin n_fail++; $display("FAIL dual_same_addr got=%h exp=11", rd_data[31:0]); end
    wa_en = 1'b1; wa_token = ~mbuf_a; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_token = ~mbuf_b; wb_addr = 5'd8; wb_data = 32'h22;
    tick(); e = sbq.pop_front();
    n_chk++; if ({wa_ack, wb_ack} !== {e.aa, e.ab}) begin n_fail++; $display("FAIL dual_acks2 got=%b exp=%b", {wa_ack, wb_ack}, {e.aa, e.ab}); end
    wa_en = 1'b0; wb_en = 1'b0; ra0 = 5'd7; ra1 = 5'd8;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data !== {32'h22, 32'h11}) begin n_fail++; $display("FAIL dual_diff_addr got=%h exp=%h", rd_data, {32'h22, 32'h11}); end
    n_chk++; if (rd_data !== {e.rd1, e.rd0}) begin n_fail++; $display("FAIL dual_model got=%h exp=%h", rd_data, {e.rd1, e.rd0}); end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    wb_en = 1'b1; wb_token = ~mbuf_b; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick(); e = sbq.pop_front();
    n_chk++; if (wb_ack !== 1'b1) begin n_fail++; $display("FAIL zero_ack got=%b exp=1", wb_ack); end
    n_chk++; if (wb_ack0 !== 1'b1) begin n_fail++; $display("FAIL zero_ack_nz got=%b exp=1", wb_ack0); end
    wb_en = 1'b0; ra0 = 5'd0;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_read got=%h exp=0", rd_data[31:0]); end
    n_chk++; if (rd_data0[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zero_off_read got=%h exp=ffffffff", rd_data0[31:0]); end
    n_chk++; if (rd_data0[31:0] !== e.rz) begin n_fail++; $display("FAIL zero_off_model got=%h exp=%h", rd_data0[31:0], e.rz); end
  endtask

  task automatic test_bypass();
    exp_t e;
    wa_en = 1'b1; wa_token = ~mbuf_a; wa_addr = 5'd4; wa_data = 32'h1;
    tick(); e = sbq.pop_front();
    wa_token = ~mbuf_a; wa_data = 32'h9; ra0 = 5'd4;
    tick(); e = sbq.pop_front();
`ifdef REGFILE_BYPASS_EN
    n_chk++; if (rd_data[31:0] !== 32'h9) begin n_fail++; $display("FAIL bypass_read got=%h exp=9", rd_data[31:0]); end
`else
    n_chk++; if (rd_data[31:0] !== 32'h1) begin n_fail++; $display("FAIL bypass_read got=%h exp=1", rd_data[31:0]); end
`endif
    n_chk++; if (rd_data[31:0] !== e.rd0) begin n_fail++; $display("FAIL bypass_model got=%h exp=%h", rd_data[31:0], e.rd0); end
    wa_en = 1'b0;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[31:0] !== 32'h9) begin n_fail++; $display("FAIL bypass_next got=%h exp=9", rd_data[31:0]); end
  endtask

  task automatic test_stall_and_reset();
    exp_t e;
    ra0 = 5'd3; ra1 = 5'd5;
    tick(); e = sbq.pop_front();
    stall = 1'b1; ra0 = 5'd7; ra1 = 5'd8;
    wa_en = 1'b1; wa_token = ~mbuf_a; wa_addr = 5'd10; wa_data = 32'h77;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data !== {32'h5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", rd_data, {32'h5, 32'hDEAD_BEEF}); end
    n_chk++; if (wa_ack !== 1'b1) begin n_fail++; $display("FAIL stall_write_ack got=%b exp=1", wa_ack); end
    wa_en = 1'b0; ra0 = 5'd10;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data !== {e.rd1, e.rd0}) begin n_fail++; $display("FAIL stall_hold2 got=%h exp=%h", rd_data, {e.rd1, e.rd0}); end
    stall = 1'b0;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL stall_write_landed got=%h exp=77", rd_data[31:0]); end
    #3 reset_n = 1'b0;
    #1;
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL async_reset_rd got=%h exp=0", rd_data); end
    model_reset();
    wa_en = 1'b1; wa_token = 1'b0; wa_addr = 5'd12; wa_data = 32'h1234;
    @(posedge CLK); #1;
    wa_en = 1'b0;
    reset_n = 1'b1;
    wa_en = 1'b1; wa_token = 1'b1; wa_addr = 5'd11; wa_data = 32'hABC;
    tick(); e = sbq.pop_front();
    n_chk++; if (wa_ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_token1 got=%b exp=0", wa_ack); end
    wa_en = 1'b0; ra0 = 5'd11; ra1 = 5'd12;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL post_reset_no_write got=%h exp=0", rd_data); end
    wa_en = 1'b1; wa_token = 1'b0;
    tick(); e = sbq.pop_front();
    n_chk++; if (wa_ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_token0 got=%b exp=1", wa_ack); end
    wa_en = 1'b0;
    tick(); e = sbq.pop_front();
    n_chk++; if (rd_data[31:0] !== 32'hABC) begin n_fail++; $display("FAIL post_reset_read got=%h exp=abc", rd_data[31:0]); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      m1[k] = '0;
      m0[k] = '0;
    end
    test_reset();
    test_basic_write();
    test_hold_token();
    test_dual();
    test_zero_reg();
    test_bypass();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
